// File: rtl/time_display_driver_if.sv
// time_display_driver_if: time/alarm fields in, seven-segment digits and status out
interface time_display_driver_if;
  logic       tick_2hz;
  logic       show_alarm;
  logic       mode12;
  logic       alrm;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hrs;
  logic [7:0] sec_alrm;
  logic [7:0] min_alrm;
  logic [7:0] hrs_alrm;
  logic [6:0] SEC_LSD;
  logic [6:0] SEC_MSD;
  logic [6:0] MIN_LSD;
  logic [6:0] MIN_MSD;
  logic [6:0] HR_LSD;
  logic [6:0] HR_MSD;
  logic       pm;
  logic       busy;
  modport master (
    output tick_2hz, show_alarm, mode12, alrm, sec, min, hrs, sec_alrm, min_alrm, hrs_alrm,
    input  SEC_LSD, SEC_MSD, MIN_LSD, MIN_MSD, HR_LSD, HR_MSD, pm, busy
  );
  modport slave (
    input  tick_2hz, show_alarm, mode12, alrm, sec, min, hrs, sec_alrm, min_alrm, hrs_alrm,
    output SEC_LSD, SEC_MSD, MIN_LSD, MIN_MSD, HR_LSD, HR_MSD, pm, busy
  );
endinterface

// File: rtl/time_display_driver.sv
// time_display_driver: sequential double-dabble of sec/min/hrs into six active-low digits,
// with 12/24-hour mapping, PM flag and alarm blinking
module time_display_driver (
  input logic clk,
  input logic reset,
  time_display_driver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam logic [41:0] BLANK = {6{7'h7F}};
  state_t      state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  fld_q, fld_d;
  logic [7:0]  min_q, min_d, hr_q, hr_d;
  logic        pm_s_q, pm_s_d;
  logic [11:0] bs_q, bs_d, bm_q, bm_d, bh_q, bh_d;
  logic [41:0] sh_q, sh_d, out_q, out_d;
  logic        sh_pm_q, sh_pm_d, pm_q, pm_d, blink_q, blink_d;
  logic [7:0]  s_sel, m_sel, h_sel, h_map;
  logic        pm_map;
  logic [19:0] shf;
  function automatic logic [3:0] a3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction
  function automatic logic [13:0] pair(input logic [11:0] b);
    return |b[11:8] ? {7'h3F, 7'h3F} : {seg(b[7:4]), seg(b[3:0])};
  endfunction
  always_comb begin
    s_sel  = bus.show_alarm ? bus.sec_alrm : bus.sec;
    m_sel  = bus.show_alarm ? bus.min_alrm : bus.min;
    h_sel  = bus.show_alarm ? bus.hrs_alrm : bus.hrs;
    // out-of-range 12-hour values map to 255 so the range rule dashes them
    h_map  = !bus.mode12 ? h_sel : h_sel == 8'd0 ? 8'd12 : h_sel <= 8'd12 ? h_sel :
             h_sel <= 8'd23 ? h_sel - 8'd12 : 8'd255;
    pm_map = bus.mode12 && h_sel >= 8'd12 && h_sel <= 8'd23;
    shf    = {a3(sr_q[19:16]), a3(sr_q[15:12]), a3(sr_q[11:8]), sr_q[7:0]} << 1;
  end
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    fld_d   = fld_q;
    min_d   = min_q;
    hr_d    = hr_q;
    pm_s_d  = pm_s_q;
    bs_d    = bs_q;
    bm_d    = bm_q;
    bh_d    = bh_q;
    sh_d    = sh_q;
    sh_pm_d = sh_pm_q;
    case (state_q)
      IDLE: begin
        sr_d    = {12'd0, s_sel};
        min_d   = m_sel;
        hr_d    = h_map;
        pm_s_d  = pm_map;
        cnt_d   = 3'd0;
        fld_d   = 2'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_d  = shf;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          fld_d = fld_q + 2'd1;
          sr_d  = {12'd0, fld_q == 2'd0 ? min_q : hr_q};
          if (fld_q == 2'd0) bs_d = shf[19:8];
          if (fld_q == 2'd1) bm_d = shf[19:8];
          if (fld_q == 2'd2) begin
            bh_d    = shf[19:8];
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        sh_d    = {pair(bh_q), pair(bm_q), pair(bs_q)};
        sh_pm_d = pm_s_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    blink_d = !bus.alrm ? 1'b0 : bus.tick_2hz ? !blink_q : blink_q;
    out_d   = blink_q ? BLANK : sh_q;
    pm_d    = !blink_q && sh_pm_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      fld_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      pm_s_q  <= 1'b0;
      bs_q    <= '0;
      bm_q    <= '0;
      bh_q    <= '0;
      sh_q    <= BLANK;
      sh_pm_q <= 1'b0;
      blink_q <= 1'b0;
      out_q   <= BLANK;
      pm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      fld_q   <= fld_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pm_s_q  <= pm_s_d;
      bs_q    <= bs_d;
      bm_q    <= bm_d;
      bh_q    <= bh_d;
      sh_q    <= sh_d;
      sh_pm_q <= sh_pm_d;
      blink_q <= blink_d;
      out_q   <= out_d;
      pm_q    <= pm_d;
    end
  end
  assign {bus.HR_MSD, bus.HR_LSD, bus.MIN_MSD, bus.MIN_LSD, bus.SEC_MSD, bus.SEC_LSD} = out_q;
  assign bus.pm   = pm_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_time_display_driver.sv
// tb_time_display_driver: directed checks of conversion, hour mapping, blink and reset behaviour
module tb_time_display_driver;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int n;
  logic [41:0] dig;
  localparam logic [41:0] BL = {6{7'h7F}};
  localparam logic [41:0] E1 = {7'h79, 7'h30, 7'h40, 7'h12, 7'h40, 7'h10};
  localparam logic [41:0] E2 = {7'h40, 7'h79, 7'h40, 7'h12, 7'h40, 7'h10};
  localparam logic [41:0] E3 = {7'h79, 7'h24, 7'h40, 7'h12, 7'h40, 7'h10};
  localparam logic [41:0] E5 = {7'h3F, 7'h3F, 7'h40, 7'h12, 7'h40, 7'h10};
  localparam logic [41:0] A1 = {7'h24, 7'h30, 7'h12, 7'h10, 7'h40, 7'h40};
  localparam logic [41:0] A2 = {7'h24, 7'h30, 7'h3F, 7'h3F, 7'h40, 7'h40};
  localparam logic [41:0] A3 = {7'h79, 7'h79, 7'h12, 7'h10, 7'h40, 7'h40};
  localparam logic [41:0] R1 = {7'h79, 7'h30, 7'h40, 7'h12, 7'h79, 7'h40};
  localparam logic [41:0] R2 = {7'h79, 7'h30, 7'h40, 7'h12, 7'h79, 7'h79};
  time_display_driver_if bus ();
  time_display_driver dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign dig = {bus.HR_MSD, bus.HR_LSD, bus.MIN_MSD, bus.MIN_LSD, bus.SEC_MSD, bus.SEC_LSD};
  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic disp(input string tag, input logic [41:0] e, input logic epm);
    chk({tag, "_dig"}, {22'd0, dig}, {22'd0, e});
    chk({tag, "_pm"}, {63'd0, bus.pm}, {63'd0, epm});
  endtask
  task automatic pulse();
    bus.tick_2hz = 1'b1;
    step();
    bus.tick_2hz = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.tick_2hz = 0; bus.show_alarm = 0; bus.mode12 = 0; bus.alrm = 0;
    bus.sec = 8'd9; bus.min = 8'd5; bus.hrs = 8'd13;
    bus.sec_alrm = 8'd0; bus.min_alrm = 8'd59; bus.hrs_alrm = 8'd23;
    step();
    disp("reset", BL, 1'b0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    reset = 1'b0;
    step();
    chk("busy_shift", {63'd0, bus.busy}, 64'd1);
    for (int i = 2; i <= 26; i++) begin
      step();
      if (i == 25) chk("busy_commit", {63'd0, bus.busy}, 64'd1);
      chk("blank_pre27", {22'd0, dig}, {22'd0, BL});
    end
    chk("busy_idle", {63'd0, bus.busy}, 64'd0);
    step();
    disp("first_27", E1, 1'b0);
    bus.mode12 = 1'b1;
    step(54);
    disp("h12_13", E2, 1'b1);
    bus.hrs = 8'd0;
    step(54);
    disp("h12_0", E3, 1'b0);
    bus.hrs = 8'd12;
    step(54);
    disp("h12_12", E3, 1'b1);
    bus.hrs = 8'd30;
    step(54);
    disp("h12_30", E5, 1'b0);
    bus.mode12 = 1'b0; bus.hrs = 8'd100;
    step(54);
    disp("h24_100", E5, 1'b0);
    bus.show_alarm = 1'b1;
    step(54);
    disp("alarm", A1, 1'b0);
    bus.min_alrm = 8'd200;
    step(54);
    disp("alarm_min200", A2, 1'b0);
    bus.min_alrm = 8'd59; bus.mode12 = 1'b1;
    step(54);
    disp("alarm_12h", A3, 1'b1);
    bus.alrm = 1'b1;
    step(3);
    pulse();
    disp("blink_tick_edge", A3, 1'b1);
    step();
    disp("blink_on1", BL, 1'b0);
    step(8);
    pulse();
    step();
    disp("blink_off", A3, 1'b1);
    step(8);
    pulse();
    step();
    disp("blink_on2", BL, 1'b0);
    step(4);
    bus.alrm = 1'b0;
    step();
    disp("alrm_fall_1", BL, 1'b0);
    step();
    disp("alrm_fall_2", A3, 1'b1);
    bus.alrm = 1'b1;
    pulse();
    step();
    disp("same_cycle", BL, 1'b0);
    bus.alrm = 1'b0;
    step(2);
    disp("same_cycle_clr", A3, 1'b1);
    bus.show_alarm = 1'b0; bus.mode12 = 1'b0;
    bus.sec = 8'd10; bus.min = 8'd5; bus.hrs = 8'd13;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.busy !== 1'b0 && n < 40);
    chk("sync_idle", {63'd0, bus.busy}, 64'd0);
    step(13);
    reset = 1'b1;
    step();
    reset = 1'b0;
    disp("mid_reset", BL, 1'b0);
    chk("mid_reset_busy", {63'd0, bus.busy}, 64'd0);
    step(26);
    disp("post_reset_26", BL, 1'b0);
    step();
    disp("post_reset_27", R1, 1'b0);
    step(5);
    bus.sec = 8'd11;
    step(46);
    disp("midshift_old", R1, 1'b0);
    step();
    disp("midshift_new", R2, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
